// File: rtl/drain_collector.sv
// ============================================================================
// drain_collector : drain-channel column sink, FIFO + valid/ready re-presenter
// Rev 1.0
// ============================================================================
`default_nettype none

package drain_collector_pkg;
  typedef struct packed {
    logic        enable;
    logic [15:0] data;
  } drain_data_t;
endpackage

module drain_collector
  import drain_collector_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int NUM_RESULTS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  drain_data_t ch_down_i,
  output drain_data_t out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic        stray_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_RESULTS + 1);
  localparam int DW = $bits(drain_data_t);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_RESULTS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   count;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [AW:0]     occupancy;
  logic [DW:0]     mem [DEPTH];
  logic [DW:0]     head;

  logic empty, full, pop, push, drop;
  logic arrival, collecting, stray_hit, start_ok, final_arrival, drained;

  assign occupancy  = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign arrival    = ch_down_i.enable;
  assign collecting = (state == COLLECT);
  assign pop        = !empty && out_ready_i;
  // A full FIFO still accepts the push when a pop frees a slot in the same cycle.
  assign push       = arrival && collecting && (!full || pop);
  assign drop       = arrival && collecting && full && !pop;
  assign stray_hit  = arrival && !collecting;
  assign start_ok   = start_i && (state == IDLE);
  assign final_arrival = arrival && collecting && (count == LAST_IDX);
  assign drained    = empty || ((occupancy == (AW+1)'(1)) && pop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok)      state_nx = COLLECT;
      COLLECT: if (final_arrival) state_nx = FLUSH;
      FLUSH:   if (drained)       state_nx = DONE;
      DONE:                       state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
      stray_o    <= 1'b0;
    end else begin
      if (start_ok)
        count <= '0;
      else if (arrival && collecting)
        count <= count + CW'(1);

      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);

      if (start_ok)  overflow_o <= 1'b0;
      else if (drop) overflow_o <= 1'b1;

      // A stray in the same cycle as the arming start still counts.
      if (stray_hit)     stray_o <= 1'b1;
      else if (start_ok) stray_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {(count == LAST_IDX), ch_down_i};
  end

  assign head        = mem[rd_ptr[AW-1:0]];
  assign out_valid_o = !empty;
  assign out_data_o  = out_valid_o ? head[DW-1:0] : '0;
  assign out_last_o  = out_valid_o && head[DW];
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);

endmodule

`default_nettype wire

// File: doc/drain_collector.md
# drain_collector

Sink at the top of a drain-channel column. Captures the `drain_data_t` stream that the channel pipeline shifts upward, buffers it in a small FIFO, and re-presents it to the result writer through a valid/ready handshake. It counts the elements of one drain operation and signals completion. The upstream channel has no backpressure, so the collector flags, rather than stalls on, any loss.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `NUM_RESULTS`, 16: elements expected per drain operation; ≥1.

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  single-cycle pulse that arms a new drain operation.
- `ch_down_i`  in  `drain_data_t`  top of channel column; `.enable` = element valid, whole struct is payload.
- `out_data_o`  out  `drain_data_t`  head-of-FIFO element.
- `out_valid_o`  out  1  `out_data_o` valid.
- `out_ready_i`  in  1  consumer accepts when `out_valid_o && out_ready_i`.
- `out_last_o`  out  1  head element is number `NUM_RESULTS`-1 of the operation.
- `busy_o`  out  1  state ≠ IDLE.
- `done_o`  out  1  one-cycle pulse when the operation is complete.
- `overflow_o`  out  1  sticky: element dropped because FIFO full.
- `stray_o`  out  1  sticky: element arrived while not collecting.

## Operation
- FSM states: IDLE, COLLECT, FLUSH, DONE.
  - IDLE → COLLECT on `start_i`. Clears the element count, `overflow_o` and `stray_o`.
  - COLLECT: every cycle with `ch_down_i.enable`=1 is one arrival and increments the count. When an arrival makes the count equal `NUM_RESULTS`, go to FLUSH.
  - FLUSH → DONE when the FIFO is empty, including the cycle the last entry pops.
  - DONE → IDLE unconditionally. `done_o`=1 only while in DONE.
- `start_i` outside IDLE is ignored.
- Push rule: an arrival in COLLECT is written to the FIFO with a tag bit `last` = (count == `NUM_RESULTS`-1).
  - If the FIFO is full and no pop happens that cycle, the element is discarded, `overflow_o` sets, and the count still increments.
  - Full FIFO with a simultaneous pop: the push is accepted.
- Arrivals in IDLE, FLUSH or DONE are discarded and set `stray_o`.
- Pop rule: the entry leaves on `out_valid_o && out_ready_i`.
  - `out_valid_o` = FIFO not empty.
  - `out_data_o` and `out_last_o` come from the head entry.
  - `out_data_o` is held stable while `out_valid_o && !out_ready_i`.
- Push and pop in the same cycle on a non-empty, non-full FIFO: occupancy is unchanged.
- No bypass: an element written into an empty FIFO is visible on the following cycle.
- Counter widths:
  - count: `$clog2(NUM_RESULTS+1)` bits.
  - FIFO pointers: `$clog2(DEPTH)` bits plus one wrap bit; full/empty are distinguished by the wrap bit, and pointers wrap modulo `DEPTH`.
- Sticky flags hold until the next accepted `start_i` or reset.
- Reset, asserted at any time including mid-operation:
  - state returns to IDLE;
  - FIFO is emptied;
  - count is cleared;
  - all outputs go to 0 (`out_data_o`='0, `out_valid_o`, `out_last_o`, `busy_o`, `done_o`, `overflow_o`, `stray_o` = 0);
  - buffered elements are lost.

## Timing
- `start_i` at cycle t → `busy_o`=1 at t+1. An arrival at t itself is a stray.
- Arrival at cycle t into an empty FIFO → `out_valid_o`=1 at t+1.
- Throughput is one push and one pop per cycle, sustained.
- Final entry popped at cycle p (FSM in FLUSH) → DONE at p+1, so `done_o`=1 at p+1 and `busy_o`=0 at p+2.
- If the final arrival at t finds the FIFO empty and `out_ready_i`=1:
  - t+1: FLUSH with the entry visible;
  - t+1: pop;
  - t+2: DONE.

## Test plan
- Basic (`NUM_RESULTS`=16, `DEPTH`=8): pulse `start_i`, then drive 16 consecutive enables with data 0..15, `out_ready_i`=1.
  - Outputs 0..15 in order, each 1 cycle after its arrival.
  - `out_last_o` only on 15.
  - `done_o` 1 cycle after 15 pops; no flags.
- Backpressure, same setup: hold `out_ready_i`=0 for the first 8 arrivals, then drive 1 with arrivals continuing.
  - FIFO reaches full with no drop.
  - All 16 values emerge in order; `overflow_o`=0.
- Overflow: `out_ready_i`=0 throughout, drive 10 arrivals.
  - Entries 0..7 retained; 8 and 9 dropped; `overflow_o`=1.
  - FSM stays in COLLECT with count 10.
- Stray: enable arrives in IDLE, and again in DONE.
  - `stray_o`=1, FIFO stays empty.
  - Next `start_i` clears `stray_o`.
- Reset mid-operation: assert `rst_i`=0 after 5 arrivals with 3 buffered.
  - Outputs go to 0 immediately (asynchronously).
  - After release: IDLE, empty FIFO; a new 16-element run completes normally.
- Wrap-around: 3 back-to-back operations with randomized `out_ready_i`.
  - Exactly 48 outputs in order, pointers wrap correctly.
  - 3 `done_o` pulses; `start_i` while busy is ignored.
